// File: rtl/gray_ptr_sync_mc.sv
// rtl/gray_ptr_sync_mc.sv - multi-channel Gray pointer synchroniser with level and error tracking
module gray_ptr_sync_mc #(
    parameter int ADDRSIZE = 4,
    parameter int STAGES   = 2,
    parameter int NCH      = 1,
    parameter int ERRW     = 8,
    localparam int P       = ADDRSIZE + 1
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [NCH*P-1:0]     wptr,
    input  logic [NCH*P-1:0]     rptr_bin,
    input  logic                 clr_err,
    output logic [NCH*P-1:0]     rq_wptr,
    output logic [NCH*P-1:0]     rq_wptr_bin,
    output logic [NCH-1:0]       ptr_upd,
    output logic [NCH*P-1:0]     level,
    output logic [NCH-1:0]       gray_err,
    output logic [ERRW-1:0]      err_cnt
);

    localparam logic [ERRW-1:0] CNT_MAX = '1;

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("gray_ptr_sync_mc: STAGES must be 2..4");
        end
        if (NCH < 1) begin : g_bad_nch
            $error("gray_ptr_sync_mc: NCH must be at least 1");
        end
    endgenerate

    // Synchroniser chain; stage 0 samples wptr directly and feeds only stage 1.
    logic [NCH*P-1:0] r_sync [STAGES];

    logic [NCH*P-1:0] r_level;
    logic [NCH-1:0]   r_ptr_upd;
    logic [NCH-1:0]   r_gray_err;
    logic [ERRW-1:0]  r_err_cnt;

    logic [NCH*P-1:0] w_rq_bin;
    logic [NCH-1:0]   w_chg;
    logic [NCH-1:0]   w_bad;

    function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
        logic [P-1:0] b;
        b[P-1] = g[P-1];
        for (int i = P - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Shift every channel's Gray pointer one stage per read clock.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= wptr;
            for (int s = 1; s < STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign rq_wptr = r_sync[STAGES-1];

    // Binary view of the synchronised pointer, plus next-update change and legality detection.
    always_comb begin
        w_rq_bin = '0;
        w_chg    = '0;
        w_bad    = '0;
        for (int c = 0; c < NCH; c++) begin
            w_rq_bin[c*P +: P] = gray2bin(rq_wptr[c*P +: P]);
            w_chg[c] = |(r_sync[STAGES-2][c*P +: P] ^ rq_wptr[c*P +: P]);
            w_bad[c] = $countones(r_sync[STAGES-2][c*P +: P] ^ rq_wptr[c*P +: P]) > 1;
        end
    end

    assign rq_wptr_bin = w_rq_bin;

    // Fill level is the modular distance from read to synchronised write pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_level <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_level[c*P +: P] <= w_rq_bin[c*P +: P] - rptr_bin[c*P +: P];
            end
        end
    end

    // Update pulse is registered alongside the last stage so it aligns with the new rq_wptr.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_ptr_upd <= '0;
        end else begin
            r_ptr_upd <= w_chg;
        end
    end

    // Sticky error flags and saturating error-cycle counter; a fresh error beats clr_err.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_gray_err <= '0;
            r_err_cnt  <= '0;
        end else if (clr_err) begin
            r_gray_err <= w_bad;
            r_err_cnt  <= (|w_bad) ? ERRW'(1) : '0;
        end else begin
            r_gray_err <= r_gray_err | w_bad;
            if ((|w_bad) && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + ERRW'(1);
            end
        end
    end

    assign level    = r_level;
    assign ptr_upd  = r_ptr_upd;
    assign gray_err = r_gray_err;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gray_ptr_sync_mc.sv
// tb/tb_gray_ptr_sync_mc.sv - randomized and directed bench for gray_ptr_sync_mc
module tb_gray_ptr_sync_mc;

    localparam int ADDRSIZE = 4;
    localparam int STAGES   = 3;
    localparam int NCH      = 2;
    localparam int ERRW     = 2;
    localparam int P        = ADDRSIZE + 1;
    localparam int W        = NCH * P;
    localparam int CMAX     = (1 << ERRW) - 1;
    localparam int PMASK    = (1 << P) - 1;

    logic            rclk;
    logic            rrst_n;
    logic [W-1:0]    wptr;
    logic [W-1:0]    rptr_bin;
    logic            clr_err;
    logic [W-1:0]    rq_wptr;
    logic [W-1:0]    rq_wptr_bin;
    logic [NCH-1:0]  ptr_upd;
    logic [W-1:0]    level;
    logic [NCH-1:0]  gray_err;
    logic [ERRW-1:0] err_cnt;

    gray_ptr_sync_mc #(
        .ADDRSIZE (ADDRSIZE),
        .STAGES   (STAGES),
        .NCH      (NCH),
        .ERRW     (ERRW)
    ) u_dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .wptr        (wptr),
        .rptr_bin    (rptr_bin),
        .clr_err     (clr_err),
        .rq_wptr     (rq_wptr),
        .rq_wptr_bin (rq_wptr_bin),
        .ptr_upd     (ptr_upd),
        .level       (level),
        .gray_err    (gray_err),
        .err_cnt     (err_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: history of sampled wptr values and expected outputs
    logic [W-1:0]   hist [$];
    logic [W-1:0]   m_rq;
    logic [W-1:0]   m_level;
    logic [NCH-1:0] m_upd;
    logic [NCH-1:0] m_err;
    int             m_cnt;
    int             bin_ctr [NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & PMASK;
    endfunction

    function automatic int from_gray(input int g);
        int b;
        b = 0;
        for (int s = 0; s < P; s++) b = b ^ (g >> s);
        return b & PMASK;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_rq    = '0;
        m_level = '0;
        m_upd   = '0;
        m_err   = '0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs(input string pfx);
        logic [W-1:0] exp_bin;
        exp_bin = '0;
        for (int c = 0; c < NCH; c++) exp_bin[c*P +: P] = P'(from_gray(int'(m_rq[c*P +: P])));
        check({pfx, "_rq_wptr"}, 32'(rq_wptr), 32'(m_rq));
        check({pfx, "_rq_wptr_bin"}, 32'(rq_wptr_bin), 32'(exp_bin));
        check({pfx, "_level"}, 32'(level), 32'(m_level));
        check({pfx, "_ptr_upd"}, 32'(ptr_upd), 32'(m_upd));
        check({pfx, "_gray_err"}, 32'(gray_err), 32'(m_err));
        check({pfx, "_err_cnt"}, 32'(err_cnt), 32'(m_cnt));
    endtask

    // One clock: model advances on the rising edge, outputs compared on the falling edge.
    task automatic step(input string pfx);
        logic [W-1:0]   new_rq;
        logic [NCH-1:0] bad;
        int             og, ng;
        @(posedge rclk);
        hist.push_back(wptr);
        new_rq = (hist.size() >= STAGES) ? hist[hist.size() - STAGES] : '0;
        bad = '0;
        for (int c = 0; c < NCH; c++) begin
            og = int'(m_rq[c*P +: P]);
            ng = int'(new_rq[c*P +: P]);
            m_upd[c] = (og != ng);
            bad[c]   = ($countones(og ^ ng) > 1);
            m_level[c*P +: P] = P'((from_gray(og) - int'(rptr_bin[c*P +: P])) & PMASK);
        end
        if (clr_err) begin
            m_err = bad;
            m_cnt = (bad != 0) ? 1 : 0;
        end else begin
            m_err = m_err | bad;
            if (bad != 0 && m_cnt < CMAX) m_cnt++;
        end
        m_rq = new_rq;
        @(negedge rclk);
        check_outputs(pfx);
    endtask

    task automatic set_ch(input int c, input int g);
        wptr[c*P +: P] = P'(g);
    endtask

    initial begin
        rrst_n   = 1'b0;
        wptr     = '0;
        rptr_bin = '0;
        clr_err  = 1'b0;
        for (int c = 0; c < NCH; c++) bin_ctr[c] = 0;
        model_reset();
        repeat (2) @(negedge rclk);
        check_outputs("reset");
        rrst_n = 1'b1;

        // Latency: ch0 00000 -> 00001 before edge 0
        set_ch(0, 1);
        step("lat");
        step("lat");
        step("lat");
        check("lat_rq_edge2", 32'(rq_wptr[P-1:0]), 32'd1);
        check("lat_upd_edge2", 32'(ptr_upd[0]), 32'd1);
        step("lat");
        check("lat_upd_edge3", 32'(ptr_upd[0]), 32'd0);

        // Wrap: rptr 30, wptr counts 30,31,0,1
        rptr_bin[P-1:0] = P'(30);
        set_ch(0, to_gray(30));
        repeat (STAGES + 1) step("wrap_fill");
        clr_err = 1'b1;
        step("wrap_clr");
        clr_err = 1'b0;
        set_ch(0, to_gray(31)); step("wrap");
        set_ch(0, to_gray(0));  step("wrap");
        set_ch(0, to_gray(1));  step("wrap");
        repeat (STAGES + 1) step("wrap_drain");
        check("wrap_level_final", 32'(level[P-1:0]), 32'd3);
        check("wrap_no_err", 32'(gray_err), 32'd0);

        // Illegal jump on ch1
        rptr_bin = '0;
        set_ch(0, 0);
        set_ch(1, 0);
        repeat (STAGES + 1) step("jump_fill");
        clr_err = 1'b1;
        step("jump_clr");
        clr_err = 1'b0;
        set_ch(1, 3);
        repeat (STAGES) step("jump");
        check("jump_gray_err", 32'(gray_err), 32'b10);
        check("jump_err_cnt", 32'(err_cnt), 32'd1);
        check("jump_ch0_rq", 32'(rq_wptr[P-1:0]), 32'd0);

        // Error/clear collision on ch0
        set_ch(0, 3);
        step("coll");
        step("coll");
        clr_err = 1'b1;
        step("coll_edge");
        clr_err = 1'b0;
        check("coll_gray_err", 32'(gray_err), 32'b01);
        check("coll_err_cnt", 32'(err_cnt), 32'd1);

        // Saturation: ch0 alternates 0/3, an error every cycle once the chain fills
        for (int i = 0; i < 8; i++) begin
            set_ch(0, (i % 2 == 0) ? 0 : 3);
            step("sat");
        end
        check("sat_err_cnt", 32'(err_cnt), 32'(CMAX));
        repeat (STAGES) step("sat_drain");
        clr_err = 1'b1;
        step("sat_clr");
        clr_err = 1'b0;
        check("sat_clr_cnt", 32'(err_cnt), 32'd0);

        // Mid-run reset with a value in flight
        set_ch(0, to_gray(5));
        set_ch(1, to_gray(9));
        step("mid_pre");
        rrst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_rst");
        wptr = '0;
        #1;
        rrst_n = 1'b1;
        repeat (STAGES + 2) step("mid_post");

        // Randomized traffic
        for (int c = 0; c < NCH; c++) bin_ctr[c] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 75) bin_ctr[c] = (bin_ctr[c] + 1) & PMASK;
                else if (r >= 90) bin_ctr[c] = int'($urandom_range(0, PMASK));
                set_ch(c, to_gray(bin_ctr[c]));
                rptr_bin[c*P +: P] = P'($urandom_range(0, PMASK));
            end
            clr_err = ($urandom_range(0, 9) == 0);
            step("rand");
        end
        clr_err = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gray_ptr_sync_mc.md
GRAY_PTR_SYNC_MC -- requirements
Module: gray_ptr_sync_mc

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4, giving pointer address bits; each pointer is P = ADDRSIZE+1 bits.
REQ-002 The block SHALL have parameter STAGES, default 2, giving synchroniser depth; legal values are 2..4, and elaboration SHALL fail otherwise.
REQ-003 The block SHALL have parameter NCH, default 1, giving the number of independent pointer channels; the legal minimum is 1.
REQ-004 The block SHALL have parameter ERRW, default 8, giving the error counter width.
REQ-005 The block SHALL have port rclk, input, 1 bit: read-domain clock; all state is rising-edge.
REQ-006 The block SHALL have port rrst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port wptr, input, NCH*P bits: Gray write pointers from the write domain; channel c occupies bits [c*P +: P].
REQ-008 The block SHALL have port rptr_bin, input, NCH*P bits: binary read pointers, rclk domain, packed as wptr.
REQ-009 The block SHALL have port clr_err, input, 1 bit: synchronous clear of the error flags and counter.
REQ-010 The block SHALL have port rq_wptr, output, NCH*P bits: synchronised Gray pointers.
REQ-011 The block SHALL have port rq_wptr_bin, output, NCH*P bits: binary equivalent of rq_wptr.
REQ-012 The block SHALL have port ptr_upd, output, NCH bits: per-channel pointer-changed indication.
REQ-013 The block SHALL have port level, output, NCH*P bits: per-channel fill level.
REQ-014 The block SHALL have port gray_err, output, NCH bits: per-channel sticky illegal-transition flag.
REQ-015 The block SHALL have port err_cnt, output, ERRW bits: saturating count of error cycles.

Function
REQ-016 Each channel SHALL pass wptr through a chain of STAGES flops; rq_wptr SHALL be the last stage, and a value stable on wptr at edge k SHALL appear on rq_wptr after edge k+STAGES-1.
REQ-017 No combinational logic SHALL sit between wptr and the first-stage flop, and the first stage SHALL feed only the second stage.
REQ-018 rq_wptr_bin SHALL be the combinational Gray-to-binary conversion of rq_wptr: bin[P-1] = g[P-1] and bin[i] = bin[i+1] XOR g[i].
REQ-019 level SHALL be registered as (rq_wptr_bin - rptr_bin) mod 2^P.
REQ-020 Because level is registered, it SHALL lag rq_wptr by one cycle.
REQ-021 When the write pointer has wrapped past the read pointer, level SHALL still equal the modular difference, with no sign handling.
REQ-022 ptr_upd[c] SHALL be registered and high for exactly the cycles in which rq_wptr channel c differs from its previous-cycle value.
REQ-023 gray_err[c] SHALL set when a last-stage update changes more than one bit, judged by popcount of the old XOR new value.
REQ-024 gray_err[c] SHALL set in the same cycle as the corresponding ptr_upd[c], and SHALL remain set until clr_err or reset.
REQ-025 err_cnt SHALL increment by 1 in each cycle in which any channel detects an illegal transition, regardless of how many channels err.
REQ-026 err_cnt SHALL saturate at 2^ERRW-1.
REQ-027 When clr_err is high with no new error in that cycle, gray_err SHALL go to 0 and err_cnt SHALL go to 0.
REQ-028 When clr_err coincides with a new error, the error SHALL win: the erroring channel's gray_err = 1, other channels 0, and err_cnt = 1.
REQ-029 Channels SHALL be fully independent; an event on one channel SHALL NOT affect another channel's outputs.
REQ-030 Wrap-around from Gray 10000 to 00000 (P=5) SHALL be a legal single-bit change and SHALL NOT set gray_err.

Reset
REQ-031 While rrst_n = 0, all sync stages, rq_wptr, rq_wptr_bin, level, ptr_upd, gray_err and err_cnt SHALL be 0, asynchronously.
REQ-032 After rrst_n deasserts, the first edges SHALL compare against the all-zero reset state, so a non-zero wptr propagating out SHALL produce ptr_upd.
REQ-033 That post-reset propagation SHALL set gray_err only if it differs from 0 in more than one bit; software SHALL issue clr_err after reset.
REQ-034 Reset asserted mid-operation SHALL abort any in-flight value, and outputs SHALL be 0 within the same cycle.

Verification
REQ-035 Latency: STAGES=3, wptr changes 00000->00001 before edge 0 -> rq_wptr = 00001, rq_wptr_bin = 00001 and ptr_upd = 1 after edge 2; ptr_upd = 0 after edge 3.
REQ-036 Wrap: P=5, rptr_bin=30, wptr Gray-counts binary 30,31,0,1 -> level sequence 0,1,2,3; gray_err stays 0.
REQ-037 Illegal jump: wptr 00000->00011 on ch1 of NCH=2 -> gray_err = 2'b10 and err_cnt = 1; ch0 outputs unchanged.
REQ-038 Error/clear collision: clr_err high in the cycle of a new ch0 error -> gray_err[0] = 1 and err_cnt = 1.
REQ-039 Saturation: ERRW=2 with 5 error cycles -> err_cnt = 3; then clr_err -> err_cnt = 0.
REQ-040 Mid-run reset: rrst_n pulses low between edges while a value is in the chain -> all outputs 0 immediately; the in-flight value is never presented.
